fifo_ast_reader: RTL

Drains the sample FIFO (16-bit ADC words, Altera FIFO in normal read mode) and presents the words as an Avalon-ST source to the FIR filter sink. This block is the read side of the FIFO: it issues rdreq, absorbs the FIFO read latency in a small credit-controlled skid buffer, and honours sink backpressure without losing or duplicating a word. It sits between FIFO_IP.q/empty/rdreq and FIR_FILTER_ast.ast_sink_*.

---
 rtl/fifo_ast_reader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fifo_ast_reader.sv
// Read side of the ADC sample FIFO. Issues rdreq under a credit limit, absorbs the
// FIFO read latency in a small skid buffer, and presents words as an Avalon-ST
// source with ready latency 0.
module fifo_ast_reader #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BUF_DEPTH  = 4
) (
    input  logic              SYS_CLK,
    input  logic              RST_N,
    input  logic              ENA,
    input  logic              FLUSH,
    input  logic              FIFO_EMPTY,
    input  logic [DATA_W-1:0] FIFO_Q,
    output logic              FIFO_RDREQ,
    output logic [DATA_W-1:0] AST_DATA,
    output logic              AST_VALID,
    input  logic              AST_READY,
    output logic [15:0]       WORD_CNT,
    output logic              BUSY
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0]   DepthLimit = BUF_DEPTH[CntW:0];
    localparam logic [CntW-1:0] DepthOcc   = BUF_DEPTH[CntW-1:0];

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         occ_q, occ_d;
    logic [CntW-1:0]         inflt_q, inflt_d;
    logic [PtrW-1:0]         wptr_q, wptr_d;
    logic [PtrW-1:0]         rptr_q, rptr_d;
    logic [RD_LATENCY-1:0]   lat_q, lat_d;
    logic [15:0]             word_cnt_q, word_cnt_d;
    logic [DATA_W-1:0]       mem_q [BUF_DEPTH];

    logic                    rdreq;
    logic                    tap;
    logic                    capture;
    logic                    pop;
    logic [CntW:0]           credit_used;

    // Credit covers both buffered words and reads whose data has not yet returned,
    // so a capture can never find the buffer full.
    assign credit_used = {1'b0, occ_q} + {1'b0, inflt_q};
    assign rdreq       = (state_q == StRun) & ~FIFO_EMPTY & ~FLUSH & (credit_used < DepthLimit);
    assign tap         = lat_q[RD_LATENCY-1];
    // Data returning from a read issued before a flush is dropped.
    assign capture     = tap & ~FLUSH;
    assign pop         = AST_VALID & AST_READY;

    assign FIFO_RDREQ  = rdreq;
    assign AST_VALID   = (occ_q != '0);
    assign AST_DATA    = mem_q[rptr_q];
    assign WORD_CNT    = word_cnt_q;
    assign BUSY        = (state_q != StIdle) | (occ_q != '0) | (inflt_q != '0);

    // FSM next state; FLUSH overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ENA) state_d = StRun;
            StRun:   if (!ENA) state_d = StDrain;
            StDrain: begin
                if (ENA) begin
                    state_d = StRun;
                end else if ((inflt_q == '0) && (occ_q == '0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (FLUSH) state_d = StIdle;
    end

    // Datapath next state: latency pipe, credit counters, pointers, word counter.
    always_comb begin
        lat_d      = '0;
        occ_d      = occ_q + CntW'(capture) - CntW'(pop);
        inflt_d    = inflt_q + CntW'(rdreq) - CntW'(tap);
        wptr_d     = wptr_q + PtrW'(capture);
        rptr_d     = rptr_q + PtrW'(pop);
        word_cnt_d = word_cnt_q + 16'(pop);
        if (FLUSH) begin
            occ_d   = '0;
            inflt_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end else begin
            lat_d[0] = rdreq;
            for (int i = 1; i < RD_LATENCY; i++) begin
                lat_d[i] = lat_q[i-1];
            end
        end
    end

    // State registers and skid-buffer storage.
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            occ_q      <= '0;
            inflt_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            lat_q      <= '0;
            word_cnt_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflt_q    <= inflt_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            lat_q      <= lat_d;
            word_cnt_q <= word_cnt_d;
            if (capture) begin
                mem_q[wptr_q] <= FIFO_Q;
            end
        end
    end

`ifndef SYNTHESIS
    // A capture into a full buffer without a simultaneous pop means the credit logic is broken.
    assert property (@(posedge SYS_CLK) disable iff (!RST_N)
                     !(capture && !pop && (occ_q == DepthOcc)))
        else $error("fifo_ast_reader: skid buffer overflow");
`endif

endmodule
